// File: rtl/risc16_run_ctrl.sv
// Run/debug sequencer for risc16_processor: gates the core with a clock enable, drives its
// reset and stops it on the HALT idiom, a PC breakpoint or a cycle-budget timeout.
module risc16_run_ctrl #(
  parameter logic [15:0] HALT_INSTR = 16'hC07F,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TO_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_reset,
  input  logic            cmd_run,
  input  logic            cmd_step,
  input  logic            cmd_halt,
  input  logic            bp_en,
  input  logic [15:0]     bp_addr,
  input  logic [TO_W-1:0] timeout_limit,
  input  logic [15:0]     pc,
  input  logic [15:0]     instruction,
  output logic            cpu_en,
  output logic            cpu_rst,
  output logic [2:0]      state,
  output logic [1:0]      halt_cause,
  output logic            step_done,
  output logic [31:0]     cycle_count
);

  localparam logic [2:0] ST_RST_HOLD = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_RUN      = 3'd2;
  localparam logic [2:0] ST_STEP     = 3'd3;
  localparam logic [2:0] ST_HALTED   = 3'd4;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_SELF    = 2'd1;
  localparam logic [1:0] CAUSE_BREAK   = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              bp_skip_q, bp_skip_d;
  logic [TO_W-1:0]   run_cnt_q, run_cnt_d;
  logic [1:0]        cause_q, cause_d;
  logic              step_done_q, step_done_d;
  logic [31:0]       cycle_q, cycle_d;
  logic              cpu_rst_q;

  logic self_hit, brk_hit, tmo_hit, stop_now, abort;

  always_comb begin
    self_hit = (instruction == HALT_INSTR);
    brk_hit  = bp_en & (pc == bp_addr) & ~bp_skip_q;
    tmo_hit  = (timeout_limit != '0) & (run_cnt_q >= timeout_limit);
    stop_now = self_hit | brk_hit | tmo_hit | cmd_halt;
    abort    = rst | cmd_reset;
  end

  // A stopping instruction is never executed; reset requests kill the enable immediately.
  always_comb begin
    cpu_en = 1'b0;
    case (state_q)
      ST_RUN:  cpu_en = ~stop_now;
      ST_STEP: cpu_en = ~self_hit;
      default: cpu_en = 1'b0;
    endcase
    if (abort) begin
      cpu_en = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    bp_skip_d   = bp_skip_q;
    run_cnt_d   = run_cnt_q;
    cause_d     = cause_q;
    step_done_d = 1'b0;

    case (state_q)
      ST_RST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      ST_IDLE: begin
        if (cmd_step) begin
          state_d = ST_STEP;
        end else if (cmd_run) begin
          state_d   = ST_RUN;
          bp_skip_d = 1'b1;
          run_cnt_d = '0;
        end
      end

      ST_RUN: begin
        bp_skip_d = 1'b0;
        if (self_hit) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_SELF;
        end else if (brk_hit) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BREAK;
        end else if (tmo_hit) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_TIMEOUT;
        end else if (cmd_halt) begin
          state_d = ST_IDLE;
        end
        if (cpu_en && (run_cnt_q != '1)) begin
          run_cnt_d = run_cnt_q + TO_W'(1);
        end
      end

      ST_STEP: begin
        if (self_hit) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_SELF;
        end else begin
          state_d     = ST_IDLE;
          step_done_d = 1'b1;
        end
      end

      ST_HALTED: begin
        // A self-halted program can only be left through a reset.
        if (cause_q != CAUSE_SELF) begin
          if (cmd_step) begin
            state_d = ST_STEP;
            cause_d = CAUSE_NONE;
          end else if (cmd_run) begin
            state_d   = ST_RUN;
            cause_d   = CAUSE_NONE;
            bp_skip_d = 1'b1;
            run_cnt_d = '0;
          end
        end
      end

      default: begin
        state_d = ST_RST_HOLD;
        hold_d  = '0;
      end
    endcase

    if (cmd_reset) begin
      state_d     = ST_RST_HOLD;
      hold_d      = '0;
      cause_d     = CAUSE_NONE;
      step_done_d = 1'b0;
    end
  end

  always_comb begin
    cycle_d = cycle_q;
    if (cmd_reset) begin
      cycle_d = '0;
    end else if (cpu_en && (cycle_q != 32'hFFFF_FFFF)) begin
      cycle_d = cycle_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RST_HOLD;
      hold_q      <= '0;
      bp_skip_q   <= 1'b0;
      run_cnt_q   <= '0;
      cause_q     <= CAUSE_NONE;
      step_done_q <= 1'b0;
      cycle_q     <= '0;
      cpu_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      bp_skip_q   <= bp_skip_d;
      run_cnt_q   <= run_cnt_d;
      cause_q     <= cause_d;
      step_done_q <= step_done_d;
      cycle_q     <= cycle_d;
      cpu_rst_q   <= (state_d == ST_RST_HOLD);
    end
  end

  assign cpu_rst     = cpu_rst_q;
  assign state       = state_q;
  assign halt_cause  = cause_q;
  assign step_done   = step_done_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_risc16_run_ctrl.sv
// Bench for risc16_run_ctrl: a toy core walks a program image; expected stop points come from
// an event-ordering model of the halt/breakpoint/timeout rules.
module tb_risc16_run_ctrl;

  localparam logic [15:0] HALT = 16'hC07F;
  localparam int RSTC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_reset = 1'b0, cmd_run = 1'b0, cmd_step = 1'b0, cmd_halt = 1'b0;
  logic        bp_en = 1'b0;
  logic [15:0] bp_addr = 16'd0;
  logic [15:0] timeout_limit = 16'd0;
  logic [15:0] pc = 16'd0;
  logic [15:0] instruction;
  logic        cpu_en, cpu_rst, step_done;
  logic [2:0]  state;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_count;

  logic [15:0] prog [64];
  int plen = 64;
  int tests = 0, fails = 0;
  int en_cnt = 0, sd_cnt = 0, overlap = 0;

  risc16_run_ctrl #(.HALT_INSTR(HALT), .RST_CYCLES(RSTC), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_reset(cmd_reset), .cmd_run(cmd_run), .cmd_step(cmd_step),
    .cmd_halt(cmd_halt), .bp_en(bp_en), .bp_addr(bp_addr), .timeout_limit(timeout_limit),
    .pc(pc), .instruction(instruction), .cpu_en(cpu_en), .cpu_rst(cpu_rst), .state(state),
    .halt_cause(halt_cause), .step_done(step_done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Toy core: straight-line program that wraps at plen.
  assign instruction = prog[pc[5:0]];
  always @(posedge clk) begin
    if (cpu_rst) pc <= 16'd0;
    else if (cpu_en) pc <= (int'(pc) + 1 >= plen) ? 16'd0 : pc + 16'd1;
  end

  always @(negedge clk) begin
    if (cpu_en === 1'b1) en_cnt = en_cnt + 1;
    if (step_done === 1'b1) sd_cnt = sd_cnt + 1;
    if (cpu_en === 1'b1 && cpu_rst === 1'b1) overlap = overlap + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // m = {reset, run, step, halt}
  task automatic pulse(input logic [3:0] m);
    {cmd_reset, cmd_run, cmd_step, cmd_halt} = m;
    tick();
    {cmd_reset, cmd_run, cmd_step, cmd_halt} = 4'b0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (RSTC) tick();
  endtask

  task automatic load_line(input int h);
    logic [15:0] v;
    for (int i = 0; i < 64; i++) begin
      v = 16'($urandom);
      if (v == HALT) v = 16'h0000;
      prog[i] = v;
    end
    if (h >= 0) prog[h] = HALT;
    plen = 64;
  endtask

  task automatic wait_stop(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (state != 3'd2) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Straight-line program: pc equals executed count, so every event lands at a count.
  // Ties resolve SELF > BREAK > TIMEOUT; a breakpoint at pc 0 is skipped on RUN entry.
  function automatic void model_stop(input int h, input bit be, input int b, input int t,
                                     output int cnt, output int cause);
    cnt = h;
    cause = 1;
    if (be && b >= 1 && b < cnt) begin
      cnt = b;
      cause = 2;
    end
    if (t > 0 && t < cnt) begin
      cnt = t;
      cause = 3;
    end
  endfunction

  task automatic test_reset();
    int n;
    load_line(-1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
    tests++; if (cpu_en !== 1'b0) begin fails++; $display("FAIL reset_cpu_en: got %b want 0", cpu_en); end
    tests++; if (halt_cause !== 2'd0 || step_done !== 1'b0) begin
      fails++; $display("FAIL reset_flags: cause %0d step_done %b want 0 0", halt_cause, step_done);
    end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (cpu_rst !== 1'b1) break;
      n++;
      tick();
    end
    tests++; if (n !== RSTC) begin fails++; $display("FAIL reset_hold_len: got %0d want %0d", n, RSTC); end
    tests++; if (state !== 3'd1 || cpu_en !== 1'b0) begin
      fails++; $display("FAIL reset_idle: state %0d en %b want 1 0", state, cpu_en);
    end
    tests++; if (cycle_count !== 32'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
  endtask

  task automatic test_self_halt();
    bit ok;
    load_line(6);
    bp_en = 1'b0; timeout_limit = 16'd0;
    do_reset();
    pulse(4'b0100);
    wait_stop(ok);
    tests++; if (!ok) begin fails++; $display("FAIL self_wait: no stop, required stop"); end
    tests++; if (state !== 3'd4 || halt_cause !== 2'd1) begin
      fails++; $display("FAIL self_stop: state %0d cause %0d want 4 1", state, halt_cause);
    end
    tests++; if (cycle_count !== 32'd6 || pc !== 16'd6) begin
      fails++; $display("FAIL self_count: count %0d pc %0d want 6 6", cycle_count, pc);
    end
    tests++; if (cpu_en !== 1'b0) begin fails++; $display("FAIL self_en: got %b want 0", cpu_en); end
    sd_cnt = 0;
    pulse(4'b0100);
    repeat (2) tick();
    pulse(4'b0010);
    repeat (2) tick();
    tests++; if (state !== 3'd4 || cycle_count !== 32'd6 || sd_cnt !== 0) begin
      fails++; $display("FAIL self_sticky: state %0d count %0d sd %0d want 4 6 0", state, cycle_count, sd_cnt);
    end
  endtask

  task automatic test_breakpoint();
    bit ok;
    int h, b;
    h = $urandom_range(40, 8);
    b = $urandom_range(h - 1, 1);
    load_line(h);
    bp_en = 1'b1; bp_addr = 16'(b); timeout_limit = 16'd0;
    do_reset();
    pulse(4'b0100);
    wait_stop(ok);
    tests++; if (!ok || state !== 3'd4 || halt_cause !== 2'd2) begin
      fails++; $display("FAIL brk_stop: state %0d cause %0d want 4 2", state, halt_cause);
    end
    tests++; if (cycle_count !== 32'(b) || pc !== 16'(b)) begin
      fails++; $display("FAIL brk_count: count %0d pc %0d want %0d", cycle_count, pc, b);
    end
    pulse(4'b0100);
    tests++; if (state !== 3'd2 || halt_cause !== 2'd0) begin
      fails++; $display("FAIL brk_resume: state %0d cause %0d want 2 0", state, halt_cause);
    end
    wait_stop(ok);
    tests++; if (!ok || halt_cause !== 2'd1 || cycle_count !== 32'(h)) begin
      fails++; $display("FAIL brk_continue: cause %0d count %0d want 1 %0d", halt_cause, cycle_count, h);
    end
    bp_en = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    int t;
    load_line(-1);
    plen = $urandom_range(8, 3);
    bp_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      t = (k == 0) ? 5 : $urandom_range(40, 1);
      timeout_limit = 16'(t);
      do_reset();
      pulse(4'b0100);
      wait_stop(ok);
      tests++; if (!ok || state !== 3'd4 || halt_cause !== 2'd3 || cycle_count !== 32'(t)) begin
        fails++; $display("FAIL tmo_stop: state %0d cause %0d count %0d want 4 3 %0d",
                          state, halt_cause, cycle_count, t);
      end
      pulse(4'b0100);
      wait_stop(ok);
      tests++; if (!ok || halt_cause !== 2'd3 || cycle_count !== 32'(2 * t)) begin
        fails++; $display("FAIL tmo_rerun: cause %0d count %0d want 3 %0d", halt_cause, cycle_count, 2 * t);
      end
    end
    timeout_limit = 16'd0;
  endtask

  task automatic test_step();
    load_line(-1);
    do_reset();
    en_cnt = 0; sd_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      pulse(4'b0010);
      repeat (3) tick();
    end
    tests++; if (en_cnt !== 3 || sd_cnt !== 3) begin
      fails++; $display("FAIL step_pulses: en %0d done %0d want 3 3", en_cnt, sd_cnt);
    end
    tests++; if (cycle_count !== 32'd3 || state !== 3'd1 || pc !== 16'd3) begin
      fails++; $display("FAIL step_final: count %0d state %0d pc %0d want 3 1 3", cycle_count, state, pc);
    end
  endtask

  task automatic test_step_self();
    load_line(0);
    do_reset();
    sd_cnt = 0;
    pulse(4'b0010);
    repeat (2) tick();
    tests++; if (state !== 3'd4 || halt_cause !== 2'd1 || cycle_count !== 32'd0 || sd_cnt !== 0) begin
      fails++; $display("FAIL step_self: state %0d cause %0d count %0d sd %0d want 4 1 0 0",
                        state, halt_cause, cycle_count, sd_cnt);
    end
    pulse(4'b1000);
    tests++; if (state !== 3'd0 || halt_cause !== 2'd0 || cpu_rst !== 1'b1) begin
      fails++; $display("FAIL step_self_reset: state %0d cause %0d rst %b want 0 0 1",
                        state, halt_cause, cpu_rst);
    end
  endtask

  task automatic test_cmd_halt();
    int n;
    load_line(-1);
    plen = 5;
    do_reset();
    n = $urandom_range(20, 5);
    pulse(4'b0100);
    repeat (n) tick();
    pulse(4'b0001);
    tests++; if (state !== 3'd1 || halt_cause !== 2'd0 || cycle_count !== 32'(n)) begin
      fails++; $display("FAIL halt_cmd: state %0d cause %0d count %0d want 1 0 %0d",
                        state, halt_cause, cycle_count, n);
    end
    pulse(4'b0100);
    repeat (2) tick();
    pulse(4'b0001);
    tests++; if (state !== 3'd1 || cycle_count !== 32'(n + 2)) begin
      fails++; $display("FAIL halt_resume: state %0d count %0d want 1 %0d", state, cycle_count, n + 2);
    end
  endtask

  task automatic test_reset_abort();
    load_line(-1);
    plen = 7;
    do_reset();
    pulse(4'b0100);
    repeat ($urandom_range(9, 2)) tick();
    cmd_reset = 1'b1; cmd_halt = 1'b1;
    #1;
    tests++; if (cpu_en !== 1'b0) begin fails++; $display("FAIL abort_run_en: got %b want 0", cpu_en); end
    tick();
    cmd_reset = 1'b0; cmd_halt = 1'b0;
    tests++; if (state !== 3'd0 || cycle_count !== 32'd0 || cpu_rst !== 1'b1) begin
      fails++; $display("FAIL abort_run: state %0d count %0d rst %b want 0 0 1", state, cycle_count, cpu_rst);
    end
    repeat (RSTC) tick();
    sd_cnt = 0;
    pulse(4'b0010);
    rst = 1'b1;
    #1;
    tests++; if (cpu_en !== 1'b0) begin fails++; $display("FAIL abort_step_en: got %b want 0", cpu_en); end
    tick();
    rst = 1'b0;
    repeat (2) tick();
    tests++; if (sd_cnt !== 0 || cycle_count !== 32'd0) begin
      fails++; $display("FAIL abort_step: sd %0d count %0d want 0 0", sd_cnt, cycle_count);
    end
  endtask

  task automatic test_random_stops();
    bit ok;
    int h, b, t, cnt, cause;
    bit be;
    for (int k = 0; k < 16; k++) begin
      h  = $urandom_range(40, 1);
      be = 1'($urandom);
      b  = $urandom_range(45, 0);
      t  = ($urandom_range(2, 0) == 0) ? 0 : $urandom_range(45, 1);
      if (k == 0) begin be = 1'b1; b = h; t = h; end
      if (k == 1) begin be = 1'b1; b = 0; t = 0; end
      if (k == 2) begin be = 1'b1; b = h - 1 + 1; t = b; if (h > 2) begin b = h - 2; t = b; end end
      model_stop(h, be, b, t, cnt, cause);
      load_line(h);
      bp_en = be; bp_addr = 16'(b); timeout_limit = 16'(t);
      do_reset();
      pulse(4'b0100);
      wait_stop(ok);
      tests++; if (!ok || state !== 3'd4 || halt_cause !== 2'(cause) || cycle_count !== 32'(cnt)) begin
        fails++; $display("FAIL rand_stop[%0d]: state %0d cause %0d count %0d want 4 %0d %0d (h%0d b%0d/%0d t%0d)",
                          k, state, halt_cause, cycle_count, cause, cnt, h, b, be, t);
      end
    end
    bp_en = 1'b0; timeout_limit = 16'd0;
  endtask

  initial begin
    test_reset();
    test_self_halt();
    test_breakpoint();
    test_timeout();
    test_step();
    test_step_self();
    test_cmd_halt();
    test_reset_abort();
    test_random_stops();
    tests++; if (overlap !== 0) begin fails++; $display("FAIL en_rst_overlap: got %0d want 0", overlap); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
